// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequenced RV32M multiply/divide unit.
// Holds the funct3 operation encodings, FSM states and overflow constants.
package muldiv_pkg;

  localparam int unsigned MD_DATA_WIDTH = 32;
  localparam int unsigned MD_TAG_WIDTH  = 5;

  // Signed overflow case for DIV/REM: most-negative dividend over -1.
  localparam logic [MD_DATA_WIDTH-1:0] MD_SIGNED_MIN = {1'b1, {(MD_DATA_WIDTH-1){1'b0}}};
  localparam logic [MD_DATA_WIDTH-1:0] MD_ALL_ONES   = {MD_DATA_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } muldiv_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (combinational).
// Ports: rem/quo/divisor in -> rem_next/quo_next out.
// The dividend is shifted out of quo MSB-first while quotient bits fill in from the LSB.
module div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quo_next
);

  logic [W:0] shifted;
  logic [W:0] trial;

  always_comb begin
    // rem < divisor holds on entry, so the shifted value fits in W+1 bits
    // and a set MSB of the trial difference means it went negative.
    shifted = {rem, quo[W-1]};
    trial   = shifted - {1'b0, divisor};
    if (!trial[W]) begin
      rem_next = trial[W-1:0];
      quo_next = {quo[W-2:0], 1'b1};
    end else begin
      rem_next = shifted[W-1:0];
      quo_next = {quo[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequenced RV32M multiply/divide unit beside the EX-stage ALU.
// Ports: clk, rst (sync, active-high); start/op/op1/op2/tag_in request;
// flush aborts in-flight work; ready/busy handshake and stall; done pulse
// with registered result/tag_out held until the next completion.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MD_DATA_WIDTH,
  parameter int unsigned TAG_WIDTH  = MD_TAG_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic [TAG_WIDTH-1:0]  tag_in,
  input  logic                  flush,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [TAG_WIDTH-1:0]  tag_out
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ONES = {DATA_WIDTH{1'b1}};

  muldiv_state_e         state_q, state_d;
  muldiv_op_e            op_q, op_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d, tag_out_q, tag_out_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  done_q, done_d, ready_q, ready_d, busy_q, busy_d;

  logic [DATA_WIDTH-1:0]   step_rem, step_quo;
  logic [2*DATA_WIDTH-1:0] a_ext, b_ext, product;
  logic [DATA_WIDTH-1:0]   mul_res, fix_res;
  logic                    accept, in_signed, in_special;

  div_step #(.W(DATA_WIDTH)) u_div_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Product at double width; operand signedness selected by the latched op.
  always_comb begin
    a_ext   = {{DATA_WIDTH{(op_q != OP_MULHU) & op1_q[DATA_WIDTH-1]}}, op1_q};
    b_ext   = {{DATA_WIDTH{((op_q == OP_MUL) || (op_q == OP_MULH)) & op2_q[DATA_WIDTH-1]}}, op2_q};
    product = a_ext * b_ext;
    mul_res = (op_q == OP_MUL) ? product[DATA_WIDTH-1:0] : product[2*DATA_WIDTH-1:DATA_WIDTH];
  end

  // Sign correction and special cases for the divide family.
  always_comb begin
    logic is_rem, is_sgn;
    is_rem = (op_q == OP_REM) || (op_q == OP_REMU);
    is_sgn = (op_q == OP_DIV) || (op_q == OP_REM);
    if (op2_q == '0) begin
      fix_res = is_rem ? op1_q : ONES;
    end else if (is_sgn && (op1_q == SMIN) && (op2_q == ONES)) begin
      fix_res = is_rem ? '0 : SMIN;
    end else if (is_rem) begin
      fix_res = (is_sgn && op1_q[DATA_WIDTH-1]) ? -rem_q : rem_q;
    end else begin
      fix_res = (is_sgn && (op1_q[DATA_WIDTH-1] ^ op2_q[DATA_WIDTH-1])) ? -quo_q : quo_q;
    end
  end

  // Request classification on the raw inputs.
  always_comb begin
    accept     = start && ready_q && !flush;
    in_signed  = !op[0];
    in_special = (op2 == '0) || (in_signed && (op1 == SMIN) && (op2 == ONES));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    tag_d     = tag_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    tag_out_d = tag_out_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          op_d  = muldiv_op_e'(op);
          op1_d = op1;
          op2_d = op2;
          tag_d = tag_in;
          if (!op[2]) begin
            state_d = ST_MUL;
          end else if (in_special) begin
            state_d = ST_FIX;
          end else begin
            state_d = ST_DIV;
            // -SMIN wraps to SMIN, which is the correct unsigned magnitude.
            quo_d   = (in_signed && op1[DATA_WIDTH-1]) ? -op1 : op1;
            dvs_d   = (in_signed && op2[DATA_WIDTH-1]) ? -op2 : op2;
            rem_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      ST_MUL: begin
        result_d  = mul_res;
        tag_out_d = tag_q;
        done_d    = 1'b1;
        state_d   = ST_DONE;
      end
      ST_DIV: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        result_d  = fix_res;
        tag_out_d = tag_q;
        done_d    = 1'b1;
        state_d   = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush drops everything not already committed to the outputs.
    if (flush) begin
      state_d   = ST_IDLE;
      done_d    = 1'b0;
      result_d  = result_q;
      tag_out_d = tag_out_q;
    end

    ready_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
    busy_d  = (state_d == ST_MUL) || (state_d == ST_DIV) || (state_d == ST_FIX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MUL;
      op1_q     <= '0;
      op2_q     <= '0;
      tag_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      tag_out_q <= '0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      tag_q     <= tag_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      tag_out_q <= tag_out_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign tag_out = tag_out_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: multiply/divide results,
// latencies, special cases, flush, back-to-back issue and mid-op reset.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] op1, op2;
  logic [4:0]  tag_in;
  logic        flush;
  logic        ready, busy, done;
  logic [31:0] result;
  logic [4:0]  tag_out;

  int n_checks = 0;
  int n_fails  = 0;

  muldiv_seq #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .op1     (op1),
    .op2     (op2),
    .tag_in  (tag_in),
    .flush   (flush),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .tag_out (tag_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request during the current cycle; returns just after its edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t);
    start = 1'b1; op = o; op1 = a; op2 = b; tag_in = t;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Cycles after the accepting cycle until done (-1 on timeout); also counts
  // cycles before done where busy was low.
  task automatic wait_done(output int lat, output int gaps);
    lat  = -1;
    gaps = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      if (!busy) gaps++;
    end
  endtask

  task automatic run(input string name, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] t,
                     input logic [31:0] exp_res, input int exp_lat);
    int lat, gaps;
    issue(o, a, b, t);
    wait_done(lat, gaps);
    check_eq({name, " latency"}, 32'(lat), 32'(exp_lat));
    check_eq({name, " result"}, result, exp_res);
    check_eq({name, " tag"}, 32'(tag_out), 32'(t));
    check_eq({name, " busy_gaps"}, 32'(gaps), 32'd0);
    @(negedge clk);
    check_eq({name, " done_pulse"}, 32'(done), 32'd0);
    check_eq({name, " ready_after"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int lat, gaps, seen;
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    op = 3'd0; op1 = '0; op2 = '0; tag_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("reset ready", 32'(ready), 32'd1);
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset done", 32'(done), 32'd0);
    check_eq("reset result", result, 32'd0);
    check_eq("reset tag", 32'(tag_out), 32'd0);

    // Multiplies
    run("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 2);
    run("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 2);
    run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3, 32'hFFFF_FFFF, 2);
    run("mul_lo", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0001, 2);

    // Iterative divides
    run("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 34);
    run("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 34);
    run("divu",    3'b101, 32'd100, 32'd7, 5'd7, 32'd14, 34);
    run("remu",    3'b111, 32'd100, 32'd7, 5'd8, 32'd2, 34);
    run("div_min", 3'b100, 32'h8000_0000, 32'd2, 5'd9, 32'hC000_0000, 34);

    // Special cases
    run("divu_z", 3'b101, 32'h0000_1234, 32'd0, 5'd10, 32'hFFFF_FFFF, 2);
    run("remu_z", 3'b111, 32'h0000_1234, 32'd0, 5'd11, 32'h0000_1234, 2);
    run("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 2);
    run("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000, 2);

    // Flush at T+10 of a divide, then a multiply at T+11
    issue(3'b101, 32'd100, 32'd7, 5'd14);
    seen = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check_eq("flush ready", 32'(ready), 32'd1);
    check_eq("flush busy", 32'(busy), 32'd0);
    check_eq("flush result_kept", result, 32'h0000_0000);
    check_eq("flush tag_kept", 32'(tag_out), 32'd13);
    issue(3'b000, 32'd3, 32'd5, 5'd15);
    wait_done(lat, gaps);
    check_eq("post_flush latency", 32'(lat), 32'd2);
    check_eq("post_flush result", result, 32'd15);
    check_eq("post_flush tag", 32'(tag_out), 32'd15);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check_eq("flush no_done", 32'(seen), 32'd0);

    // Back-to-back: divide presented in the multiply's DONE cycle
    issue(3'b000, 32'd6, 32'd7, 5'd16);
    wait_done(lat, gaps);
    check_eq("b2b mul latency", 32'(lat), 32'd2);
    check_eq("b2b mul result", result, 32'd42);
    check_eq("b2b mul tag", 32'(tag_out), 32'd16);
    check_eq("b2b done_busy", 32'(busy), 32'd0);
    check_eq("b2b done_ready", 32'(ready), 32'd1);
    issue(3'b100, 32'd42, 32'd6, 5'd17);
    wait_done(lat, gaps);
    check_eq("b2b div latency", 32'(lat), 32'd34);
    check_eq("b2b div busy_gaps", 32'(gaps), 32'd0);
    check_eq("b2b div result", result, 32'd7);
    check_eq("b2b div tag", 32'(tag_out), 32'd17);
    @(negedge clk);

    // Reset mid-divide
    issue(3'b101, 32'd1000, 32'd3, 5'd18);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst ready", 32'(ready), 32'd1);
    check_eq("mid_rst busy", 32'(busy), 32'd0);
    check_eq("mid_rst done", 32'(done), 32'd0);
    check_eq("mid_rst result", result, 32'd0);
    check_eq("mid_rst tag", 32'(tag_out), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check_eq("mid_rst no_done", 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
